// File: rtl/pipelined_cache_miss_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cache_miss_ctrl_pkg
// Purpose  : Shared cache geometry, miss-FSM encoding and line-address helper.
// Revision : 1.0
// ============================================================================
package pipelined_cache_miss_ctrl_pkg;

    localparam int c_S_OFFSET = 5;
    localparam int c_S_INDEX  = 3;
    localparam int c_S_TAG    = 24;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ST_FILL      = 2'd2;
    localparam logic [1:0] c_ST_REPLAY    = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = c_ST_IDLE,
        WRITEBACK = c_ST_WRITEBACK,
        FILL      = c_ST_FILL,
        REPLAY    = c_ST_REPLAY
    } miss_state_t;

    // Clears the byte-offset bits of an address to form a line address.
    function automatic logic [31:0] line_mask(input int offset_bits);
        return ~((32'd1 << offset_bits) - 32'd1);
    endfunction

    localparam logic [31:0] c_LINE_MASK = line_mask(c_S_OFFSET);

endpackage
`default_nettype wire

// File: rtl/pipelined_cache_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cache_miss_ctrl_if
// Purpose  : Stage-register, physical-memory and array-control bundle.
// Revision : 1.0
// ============================================================================
interface pipelined_cache_miss_ctrl_if
    import pipelined_cache_miss_ctrl_pkg::*;
#(
    parameter int S_TAG = c_S_TAG,
    parameter int CNT_W = 16
) ();

    logic             req_valid_i;
    logic             hit_i;
    logic             dirty_i;
    logic             lru_i;
    logic [31:0]      address_i;
    logic [S_TAG-1:0] victim_tag_i;
    logic             pmem_resp_i;
    logic             cnt_clr_i;
    logic             stall_o;
    logic             force_load_o;
    logic             pmem_read_o;
    logic             pmem_write_o;
    logic [31:0]      pmem_address_o;
    logic             way_o;
    logic             load_data_o;
    logic             load_tag_o;
    logic             set_valid_o;
    logic             clr_dirty_o;
    logic [CNT_W-1:0] miss_count_o;
    logic [CNT_W-1:0] wb_count_o;

    modport master (
        input  req_valid_i, hit_i, dirty_i, lru_i, address_i, victim_tag_i,
               pmem_resp_i, cnt_clr_i,
        output stall_o, force_load_o, pmem_read_o, pmem_write_o, pmem_address_o,
               way_o, load_data_o, load_tag_o, set_valid_o, clr_dirty_o,
               miss_count_o, wb_count_o
    );

    modport slave (
        output req_valid_i, hit_i, dirty_i, lru_i, address_i, victim_tag_i,
               pmem_resp_i, cnt_clr_i,
        input  stall_o, force_load_o, pmem_read_o, pmem_write_o, pmem_address_o,
               way_o, load_data_o, load_tag_o, set_valid_o, clr_dirty_o,
               miss_count_o, wb_count_o
    );

endinterface
`default_nettype wire

// File: rtl/pipelined_cache_miss_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with clear taking priority over increment.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipelined_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cache_miss_ctrl
// Purpose  : Miss handler: victim writeback, line fill, refill and replay.
// Revision : 1.0
// ============================================================================
module pipelined_cache_miss_ctrl
    import pipelined_cache_miss_ctrl_pkg::*;
#(
    parameter int S_OFFSET = c_S_OFFSET,
    parameter int S_INDEX  = c_S_INDEX,
    parameter int S_TAG    = c_S_TAG,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    pipelined_cache_miss_ctrl_if.master bus
);

    localparam logic [31:0] c_LINE_MASK_P = line_mask(S_OFFSET);

    if (S_TAG + S_INDEX + S_OFFSET != 32) begin : g_bad_addr_split
        $error("S_TAG + S_INDEX + S_OFFSET must equal 32");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_line_addr;
    logic [S_TAG-1:0] r_victim_tag;
    logic             r_way;

    logic             w_miss;
    logic             w_miss_inc;
    logic             w_wb_inc;
    logic [31:0]      w_wb_addr;
    logic             w_stall;
    logic             w_force_load;
    logic             w_pmem_read;
    logic             w_pmem_write;
    logic [31:0]      w_pmem_addr;
    logic             w_load_data;
    logic             w_load_tag;
    logic             w_set_valid;
    logic             w_clr_dirty;
    logic [CNT_W-1:0] w_miss_count;
    logic [CNT_W-1:0] w_wb_count;

    assign w_miss     = bus.req_valid_i & ~bus.hit_i;
    assign w_miss_inc = (r_state == c_ST_IDLE) & w_miss;
    assign w_wb_inc   = w_miss_inc & bus.dirty_i;
    // Victim line lives at the same set index under the victim's own tag.
    assign w_wb_addr  = {r_victim_tag, r_line_addr[S_OFFSET+S_INDEX-1:S_OFFSET],
                         {S_OFFSET{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_line_addr  <= '0;
            r_victim_tag <= '0;
            r_way        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss_inc) begin
                r_line_addr  <= bus.address_i & c_LINE_MASK_P;
                r_victim_tag <= bus.victim_tag_i;
                r_way        <= bus.lru_i;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stall      = 1'b0;
        w_force_load = 1'b0;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
        w_pmem_addr  = '0;
        w_load_data  = 1'b0;
        w_load_tag   = 1'b0;
        w_set_valid  = 1'b0;
        w_clr_dirty  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_stall = w_miss;
                if (w_miss) begin
                    w_state_nxt = bus.dirty_i ? c_ST_WRITEBACK : c_ST_FILL;
                end
            end
            c_ST_WRITEBACK: begin
                w_stall      = 1'b1;
                w_pmem_write = 1'b1;
                w_pmem_addr  = w_wb_addr;
                if (bus.pmem_resp_i) begin
                    w_clr_dirty = 1'b1;
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                w_stall     = 1'b1;
                w_pmem_read = 1'b1;
                w_pmem_addr = r_line_addr;
                if (bus.pmem_resp_i) begin
                    w_load_data = 1'b1;
                    w_load_tag  = 1'b1;
                    w_set_valid = 1'b1;
                    w_clr_dirty = 1'b1;
                    w_state_nxt = c_ST_REPLAY;
                end
            end
            c_ST_REPLAY: begin
                // Stage registers recapture the refilled line; it hits next cycle.
                w_stall      = 1'b1;
                w_force_load = 1'b1;
                w_state_nxt  = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_inc),
        .clr   (bus.cnt_clr_i),
        .count (w_miss_count)
    );

    sat_counter #(.W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_wb_inc),
        .clr   (bus.cnt_clr_i),
        .count (w_wb_count)
    );

    assign bus.stall_o        = w_stall;
    assign bus.force_load_o   = w_force_load;
    assign bus.pmem_read_o    = w_pmem_read;
    assign bus.pmem_write_o   = w_pmem_write;
    assign bus.pmem_address_o = w_pmem_addr;
    assign bus.way_o          = r_way;
    assign bus.load_data_o    = w_load_data;
    assign bus.load_tag_o     = w_load_tag;
    assign bus.set_valid_o    = w_set_valid;
    assign bus.clr_dirty_o    = w_clr_dirty;
    assign bus.miss_count_o   = w_miss_count;
    assign bus.wb_count_o     = w_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cache_miss_ctrl
// Purpose  : Self-checking bench with memory model and transaction scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pipelined_cache_miss_ctrl;

    localparam int CNT_W = 8;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    txn_t exp_q[$];
    bit   mem_auto = 1'b1;
    bit   spur_resp = 1'b0;
    int   mem_lat = 1;
    int   busy = 0;
    int   obs_stall, obs_rd, obs_wr, obs_excl, obs_ld, obs_tag, obs_val, obs_cd, obs_fl;
    logic obs_way;

    always #5 clk = ~clk;

    pipelined_cache_miss_ctrl_if #(.S_TAG(24), .CNT_W(CNT_W)) bus ();

    pipelined_cache_miss_ctrl #(
        .S_OFFSET (5),
        .S_INDEX  (3),
        .S_TAG    (24),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One clock: memory responds after mem_lat request cycles; completions are scoreboarded.
    task automatic step();
        txn_t e;
        @(negedge clk);
        if (mem_auto) begin
            if (bus.pmem_resp_i) busy = 0;
            if (bus.pmem_read_o || bus.pmem_write_o) begin
                busy = busy + 1;
                bus.pmem_resp_i = (busy >= mem_lat);
            end else begin
                busy = 0;
                bus.pmem_resp_i = 1'b0;
            end
            if (bus.pmem_resp_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_txn: got wr=%0b addr=%h, want no transaction",
                             bus.pmem_write_o, bus.pmem_address_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.pmem_write_o !== e.wr || bus.pmem_address_o !== e.addr) begin
                        n_fail++;
                        $display("FAIL sb_txn: got wr=%0b addr=%h, want wr=%0b addr=%h",
                                 bus.pmem_write_o, bus.pmem_address_o, e.wr, e.addr);
                    end
                end
            end
        end else begin
            busy = 0;
            bus.pmem_resp_i = spur_resp;
        end
        if (rst) begin
            n_cmp++;
            if ((bus.pmem_read_o && bus.pmem_write_o) ||
                (!bus.pmem_read_o && !bus.pmem_write_o && bus.pmem_address_o != 32'h0)) begin
                n_fail++;
                $display("FAIL pmem_excl_idle: got rd=%0b wr=%0b addr=%h, want exclusive and zero idle addr",
                         bus.pmem_read_o, bus.pmem_write_o, bus.pmem_address_o);
            end
        end
        #1;
    endtask

    task automatic clear_obs();
        obs_stall = 0; obs_rd = 0; obs_wr = 0; obs_excl = 0; obs_ld = 0;
        obs_tag = 0; obs_val = 0; obs_cd = 0; obs_fl = 0; obs_way = 1'b0;
    endtask

    task automatic sample_cycle();
        if (bus.stall_o)      obs_stall++;
        if (bus.pmem_read_o)  obs_rd++;
        if (bus.pmem_write_o) obs_wr++;
        if (bus.pmem_read_o && bus.pmem_write_o) obs_excl++;
        if (bus.load_data_o) begin
            obs_ld++;
            obs_way = bus.way_o;
        end
        if (bus.load_tag_o)   obs_tag++;
        if (bus.set_valid_o)  obs_val++;
        if (bus.clr_dirty_o)  obs_cd++;
        if (bus.force_load_o) obs_fl++;
    endtask

    // Presents one miss for a single cycle and observes it until stall drops.
    task automatic run_miss(input logic [31:0] addr, input logic [23:0] vtag, input logic dirty,
                            input logic lru, input int lat, input logic clr);
        mem_lat = lat;
        if (dirty) exp_q.push_back('{wr: 1'b1, addr: {vtag, addr[7:5], 5'b0}});
        exp_q.push_back('{wr: 1'b0, addr: {addr[31:5], 5'b0}});
        step();
        bus.req_valid_i = 1'b1; bus.hit_i = 1'b0; bus.address_i = addr;
        bus.victim_tag_i = vtag; bus.dirty_i = dirty; bus.lru_i = lru; bus.cnt_clr_i = clr;
        #1;
        clear_obs();
        while (bus.stall_o) begin
            sample_cycle();
            if (obs_stall > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL miss_timeout: got stall still high after %0d cycles, want release", obs_stall);
                break;
            end
            step();
            bus.req_valid_i = 1'b0; bus.cnt_clr_i = 1'b0;
        end
        bus.req_valid_i = 1'b0; bus.cnt_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({bus.stall_o, bus.force_load_o, bus.pmem_read_o, bus.pmem_write_o, bus.way_o, bus.load_data_o,
             bus.load_tag_o, bus.set_valid_o, bus.clr_dirty_o} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 0", {bus.stall_o, bus.force_load_o, bus.pmem_read_o,
                     bus.pmem_write_o, bus.way_o, bus.load_data_o, bus.load_tag_o, bus.set_valid_o, bus.clr_dirty_o});
        end
        n_cmp++;
        if (bus.pmem_address_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h, want 0", bus.pmem_address_o);
        end
        n_cmp++;
        if ({bus.miss_count_o, bus.wb_count_o} !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h, want 0/0", bus.miss_count_o, bus.wb_count_o);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_stall: got %b, want 0", bus.stall_o);
        end
    endtask

    task automatic test_clean_miss();
        run_miss(32'h0000_1234, 24'h123456, 1'b0, 1'b1, 3, 1'b0);
        n_cmp++; if (obs_stall !== 5) begin n_fail++; $display("FAIL clean_stall: got %0d want 5", obs_stall); end
        n_cmp++; if (obs_rd !== 3 || obs_wr !== 0) begin n_fail++; $display("FAIL clean_rdwr: got rd=%0d wr=%0d want 3/0", obs_rd, obs_wr); end
        n_cmp++;
        if (obs_ld !== 1 || obs_tag !== 1 || obs_val !== 1 || obs_cd !== 1 || obs_way !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_refill: got ld=%0d tag=%0d val=%0d cd=%0d way=%0b want 1/1/1/1/1",
                     obs_ld, obs_tag, obs_val, obs_cd, obs_way);
        end
        n_cmp++; if (obs_fl !== 1) begin n_fail++; $display("FAIL clean_force: got %0d want 1", obs_fl); end
        n_cmp++;
        if (bus.miss_count_o !== 8'd1 || bus.wb_count_o !== 8'd0) begin
            n_fail++; $display("FAIL clean_cnt: got %0d/%0d want 1/0", bus.miss_count_o, bus.wb_count_o);
        end
    endtask

    task automatic test_dirty_miss();
        run_miss(32'h0000_2040, 24'h00ABCD, 1'b1, 1'b0, 2, 1'b0);
        n_cmp++; if (obs_stall !== 6) begin n_fail++; $display("FAIL dirty_stall: got %0d want 6", obs_stall); end
        n_cmp++; if (obs_wr !== 2 || obs_rd !== 2) begin n_fail++; $display("FAIL dirty_rdwr: got rd=%0d wr=%0d want 2/2", obs_rd, obs_wr); end
        n_cmp++;
        if (obs_cd !== 2 || obs_ld !== 1 || obs_fl !== 1 || obs_way !== 1'b0) begin
            n_fail++;
            $display("FAIL dirty_pulses: got cd=%0d ld=%0d fl=%0d way=%0b want 2/1/1/0", obs_cd, obs_ld, obs_fl, obs_way);
        end
        n_cmp++;
        if (bus.miss_count_o !== 8'd2 || bus.wb_count_o !== 8'd1) begin
            n_fail++; $display("FAIL dirty_cnt: got %0d/%0d want 2/1", bus.miss_count_o, bus.wb_count_o);
        end
    endtask

    task automatic test_hit_spurious();
        mem_auto = 1'b0;
        step();
        bus.req_valid_i = 1'b1; bus.hit_i = 1'b1; bus.dirty_i = 1'b1; bus.address_i = 32'h0000_5000;
        spur_resp = 1'b1;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) spur_resp = 1'b0;
            sample_cycle();
        end
        n_cmp++;
        if (obs_stall + obs_rd + obs_wr + obs_fl + obs_ld + obs_cd !== 0) begin
            n_fail++;
            $display("FAIL hit_quiet: got stall=%0d rd=%0d wr=%0d fl=%0d ld=%0d cd=%0d want all 0",
                     obs_stall, obs_rd, obs_wr, obs_fl, obs_ld, obs_cd);
        end
        n_cmp++;
        if (bus.miss_count_o !== 8'd2 || bus.wb_count_o !== 8'd1) begin
            n_fail++; $display("FAIL hit_cnt: got %0d/%0d want 2/1", bus.miss_count_o, bus.wb_count_o);
        end
        bus.req_valid_i = 1'b0; bus.hit_i = 1'b0; bus.dirty_i = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_back_to_back();
        mem_lat = 1;
        exp_q.push_back('{wr: 1'b0, addr: 32'h0000_3000});
        exp_q.push_back('{wr: 1'b1, addr: 32'h5A5A_5A60});
        exp_q.push_back('{wr: 1'b0, addr: 32'h0000_4460});
        step();
        bus.req_valid_i = 1'b1; bus.hit_i = 1'b0; bus.address_i = 32'h0000_3000;
        bus.dirty_i = 1'b0; bus.lru_i = 1'b0; bus.victim_tag_i = 24'h0;
        #1;
        clear_obs();
        for (int c = 0; c < 100; c++) begin
            if (!bus.stall_o) break;
            sample_cycle();
            if (bus.force_load_o) begin
                if (obs_fl == 1) begin
                    bus.address_i = 32'h0000_4460; bus.dirty_i = 1'b1;
                    bus.victim_tag_i = 24'h5A5A5A; bus.lru_i = 1'b1;
                end else begin
                    bus.req_valid_i = 1'b0;
                end
            end
            step();
        end
        bus.req_valid_i = 1'b0; bus.dirty_i = 1'b0;
        n_cmp++; if (obs_stall !== 7) begin n_fail++; $display("FAIL b2b_stall: got %0d want 7", obs_stall); end
        n_cmp++;
        if (obs_rd !== 2 || obs_wr !== 1 || obs_fl !== 2 || obs_excl !== 0 || obs_way !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_seq: got rd=%0d wr=%0d fl=%0d excl=%0d way=%0b want 2/1/2/0/1",
                     obs_rd, obs_wr, obs_fl, obs_excl, obs_way);
        end
        n_cmp++;
        if (bus.miss_count_o !== 8'd4 || bus.wb_count_o !== 8'd2) begin
            n_fail++; $display("FAIL b2b_cnt: got %0d/%0d want 4/2", bus.miss_count_o, bus.wb_count_o);
        end
    endtask

    task automatic test_reset_mid_fill();
        mem_lat = 10;
        step();
        bus.req_valid_i = 1'b1; bus.hit_i = 1'b0; bus.address_i = 32'h0000_6000; bus.dirty_i = 1'b0;
        step();
        bus.req_valid_i = 1'b0;
        n_cmp++;
        if (bus.pmem_read_o !== 1'b1) begin n_fail++; $display("FAIL rmf_in_fill: got rd=%0b want 1", bus.pmem_read_o); end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.pmem_read_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.pmem_address_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rmf_async_drop: got rd=%0b stall=%0b addr=%h want 0/0/0",
                     bus.pmem_read_o, bus.stall_o, bus.pmem_address_o);
        end
        mem_auto = 1'b0; spur_resp = 1'b1;
        clear_obs();
        step(); sample_cycle();
        step(); sample_cycle();
        rst = 1'b1;
        step(); sample_cycle();
        step(); sample_cycle();
        spur_resp = 1'b0;
        step(); sample_cycle();
        n_cmp++;
        if (obs_stall + obs_rd + obs_wr + obs_fl + obs_ld + obs_cd !== 0) begin
            n_fail++;
            $display("FAIL rmf_late_resp: got stall=%0d rd=%0d wr=%0d fl=%0d ld=%0d cd=%0d want all 0",
                     obs_stall, obs_rd, obs_wr, obs_fl, obs_ld, obs_cd);
        end
        n_cmp++;
        if (bus.miss_count_o !== 8'd0 || bus.wb_count_o !== 8'd0) begin
            n_fail++; $display("FAIL rmf_cnt: got %0d/%0d want 0/0", bus.miss_count_o, bus.wb_count_o);
        end
        mem_auto = 1'b1;
    endtask

    task automatic test_counter_saturation();
        logic [CNT_W-1:0] mid_m, mid_w;
        int               fl;
        mid_m = '0; mid_w = '0; fl = 0;
        mem_lat = 1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{wr: 1'b1, addr: 32'h1111_1100});
            exp_q.push_back('{wr: 1'b0, addr: 32'h0000_8000});
        end
        step();
        bus.req_valid_i = 1'b1; bus.hit_i = 1'b0; bus.address_i = 32'h0000_8000;
        bus.dirty_i = 1'b1; bus.victim_tag_i = 24'h111111; bus.lru_i = 1'b0;
        #1;
        for (int c = 0; c < 2000; c++) begin
            if (bus.force_load_o) begin
                fl++;
                if (fl == 255) begin mid_m = bus.miss_count_o; mid_w = bus.wb_count_o; end
                if (fl == 256) bus.req_valid_i = 1'b0;
            end
            if (fl == 256 && !bus.stall_o) break;
            step();
        end
        bus.req_valid_i = 1'b0; bus.dirty_i = 1'b0;
        n_cmp++; if (fl !== 256) begin n_fail++; $display("FAIL sat_progress: got %0d misses want 256", fl); end
        n_cmp++;
        if (mid_m !== 8'hFF || mid_w !== 8'hFF) begin
            n_fail++; $display("FAIL sat_reach: got %h/%h want ff/ff", mid_m, mid_w);
        end
        n_cmp++;
        if (bus.miss_count_o !== 8'hFF || bus.wb_count_o !== 8'hFF) begin
            n_fail++; $display("FAIL sat_hold: got %h/%h want ff/ff", bus.miss_count_o, bus.wb_count_o);
        end
        run_miss(32'h0000_9020, 24'h222222, 1'b1, 1'b0, 1, 1'b1);
        n_cmp++;
        if (bus.miss_count_o !== 8'd0 || bus.wb_count_o !== 8'd0) begin
            n_fail++; $display("FAIL clr_priority: got %0d/%0d want 0/0", bus.miss_count_o, bus.wb_count_o);
        end
        run_miss(32'h0000_A000, 24'h0, 1'b0, 1'b1, 2, 1'b0);
        n_cmp++;
        if (bus.miss_count_o !== 8'd1 || bus.wb_count_o !== 8'd0 || obs_stall !== 4) begin
            n_fail++;
            $display("FAIL post_clr_miss: got cnt=%0d/%0d stall=%0d want 1/0/4",
                     bus.miss_count_o, bus.wb_count_o, obs_stall);
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.hit_i = 1'b0; bus.dirty_i = 1'b0; bus.lru_i = 1'b0;
        bus.address_i = 32'h0; bus.victim_tag_i = 24'h0; bus.pmem_resp_i = 1'b0; bus.cnt_clr_i = 1'b0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_hit_spurious();
        test_back_to_back();
        test_reset_mid_fill();
        test_counter_saturation();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending transactions want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
